// File: rtl/inst_mem_responder_if.sv
// ---------------------------------------------------------------------------
// inst_mem_responder_if
//   Fetch request / instruction response bundle between a fetch unit
//   (master) and the instruction memory responder (slave).
//
//   Request : req_valid, target_device_flag, device, address  -> slave
//             req_ready                                        <- slave
//   Response: rsp_valid, rsp_data, rsp_pointer, rsp_last       <- slave
//             rsp_ready                                        -> slave
// ---------------------------------------------------------------------------
interface inst_mem_responder_if #(
   parameter int ADDR_WIDTH   = 8,
   parameter int DATA_WIDTH   = 16,
   parameter int DEVICE_WIDTH = 2
);
   logic                    req_valid;
   logic                    target_device_flag;
   logic [DEVICE_WIDTH-1:0] device;
   logic [ADDR_WIDTH-1:0]   address;
   logic                    req_ready;
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [DATA_WIDTH-1:0]   rsp_data;
   logic [3:0]              rsp_pointer;
   logic                    rsp_last;

   modport master (
      output req_valid, target_device_flag, device, address, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_pointer, rsp_last
   );

   modport slave (
      input  req_valid, target_device_flag, device, address, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_pointer, rsp_last
   );
endinterface

// File: rtl/inst_mem_responder.sv
// ---------------------------------------------------------------------------
// inst_mem_responder
//   Memory-side responder for instruction fetch. Accepts a request addressed
//   to DEVICE_ID, waits WAIT_STATES cycles, then streams BURST_LEN words
//   (wrapping modulo the array depth) tagged with their IR pointer.
//
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : fetch request / response bundle (slave side)
//   ld_en, ld_addr, ld_data : side load port into the memory array
//   busy       : high while a request is being serviced (WAIT or SEND)
// ---------------------------------------------------------------------------
module inst_mem_responder #(
   parameter int                      ADDR_WIDTH   = 8,
   parameter int                      DATA_WIDTH   = 16,
   parameter int                      DEVICE_WIDTH = 2,
   parameter logic [DEVICE_WIDTH-1:0] DEVICE_ID    = 2'b01,
   parameter int                      WAIT_STATES  = 2,
   parameter int                      BURST_LEN    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   inst_mem_responder_if.slave   bus,
   input  logic                  ld_en,
   input  logic [ADDR_WIDTH-1:0] ld_addr,
   input  logic [DATA_WIDTH-1:0] ld_data,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] base, base_nxt;
   logic [3:0]            wait_cnt, wait_nxt;
   logic [3:0]            beat, beat_nxt;

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   logic [DATA_WIDTH-1:0] data_reg;
   logic [3:0]            pointer_reg;
   logic                  last_reg;

   logic                  hit;
   logic                  fire;
   logic                  last_beat;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_word;

   assign hit       = bus.req_valid & bus.target_device_flag & (bus.device == DEVICE_ID);
   assign fire      = (state == SEND) & bus.rsp_ready;
   assign last_beat = (beat == 4'(BURST_LEN - 1));

   always_comb begin
      state_nxt = state;
      base_nxt  = base;
      wait_nxt  = wait_cnt;
      beat_nxt  = beat;
      case (state)
         IDLE: begin
            if (hit) begin
               base_nxt  = bus.address;
               wait_nxt  = 4'd0;
               beat_nxt  = 4'd0;
               state_nxt = (WAIT_STATES == 0) ? SEND : WAIT;
            end
         end
         WAIT: begin
            wait_nxt = wait_cnt + 4'd1;
            if (wait_cnt == 4'(WAIT_STATES - 1)) begin
               state_nxt = SEND;
            end
         end
         SEND: begin
            if (fire) begin
               if (last_beat) begin
                  state_nxt = IDLE;
                  beat_nxt  = 4'd0;
               end else begin
                  beat_nxt  = beat + 4'd1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The response registers are reloaded every cycle from the word that will
   // be presented next. A load to that same address in this cycle is
   // forwarded, so a held beat shows the new value from the following cycle
   // while the current cycle still shows the old one.
   assign rd_addr = base_nxt + ADDR_WIDTH'(beat_nxt);
   assign rd_word = (ld_en && (ld_addr == rd_addr)) ? ld_data : mem[rd_addr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         base        <= '0;
         wait_cnt    <= 4'd0;
         beat        <= 4'd0;
         data_reg    <= '0;
         pointer_reg <= 4'd0;
         last_reg    <= 1'b0;
      end else begin
         state       <= state_nxt;
         base        <= base_nxt;
         wait_cnt    <= wait_nxt;
         beat        <= beat_nxt;
         data_reg    <= rd_word;
         pointer_reg <= beat_nxt;
         last_reg    <= (state_nxt == SEND) && (beat_nxt == 4'(BURST_LEN - 1));
      end
   end

   // Memory contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (ld_en) begin
         mem[ld_addr] <= ld_data;
      end
   end

   // req_ready is gated by rst_n so it reads low for the whole reset window.
   assign bus.req_ready   = (state == IDLE) & rst_n;
   assign bus.rsp_valid   = (state == SEND);
   assign bus.rsp_data    = data_reg;
   assign bus.rsp_pointer = pointer_reg;
   assign bus.rsp_last    = last_reg;
   assign busy            = (state != IDLE);

endmodule

// File: tb/tb_inst_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_inst_mem_responder
//   Directed bench for inst_mem_responder with default parameters.
// ---------------------------------------------------------------------------
module tb_inst_mem_responder;

   logic        clk;
   logic        rst_n;
   logic        ld_en;
   logic [7:0]  ld_addr;
   logic [15:0] ld_data;
   logic        busy;

   int vec_cnt  = 0;
   int miss_cnt = 0;
   int hs_cnt   = 0;

   inst_mem_responder_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .DEVICE_WIDTH(2)) bus ();

   inst_mem_responder dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .ld_en   (ld_en),
      .ld_addr (ld_addr),
      .ld_data (ld_data),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.rsp_valid && bus.rsp_ready) hs_cnt <= hs_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [7:0] a, input logic [15:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      tick();
      ld_en = 1'b0;
   endtask

   // Returns one cycle after the accept edge (cycle T+1).
   task automatic issue(input logic [1:0] dev, input logic flag, input logic [7:0] a);
      bus.req_valid = 1'b1; bus.device = dev; bus.target_device_flag = flag; bus.address = a;
      tick();
      bus.req_valid = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
      check({tag, "_busy"},      32'(busy),          32'd0);
      check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
   endtask

   // Collects a full burst with rsp_ready held high; entered at cycle T+1.
   task automatic burst_plain(input string tag, input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2, input logic [15:0] w3);
      logic [15:0] exp [4];
      exp[0] = w0; exp[1] = w1; exp[2] = w2; exp[3] = w3;
      check({tag, "_wait_busy"},  32'(busy),          32'd1);
      check({tag, "_wait_ready"}, 32'(bus.req_ready), 32'd0);
      check({tag, "_wait_valid"}, 32'(bus.rsp_valid), 32'd0);
      tick();
      check({tag, "_wait2_valid"}, 32'(bus.rsp_valid), 32'd0);
      tick();
      for (int i = 0; i < 4; i++) begin
         check({tag, "_valid"}, 32'(bus.rsp_valid),   32'd1);
         check({tag, "_data"},  32'(bus.rsp_data),    32'(exp[i]));
         check({tag, "_ptr"},   32'(bus.rsp_pointer), 32'(i));
         check({tag, "_last"},  32'(bus.rsp_last),    32'(i == 3));
         tick();
      end
      check_idle({tag, "_end"});
   endtask

   initial begin
      int hs_start;
      rst_n = 1'b0;
      ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      bus.req_valid = 1'b0; bus.target_device_flag = 1'b0;
      bus.device = '0; bus.address = '0; bus.rsp_ready = 1'b1;

      // reset state
      tick(); tick();
      check("rst_req_ready", 32'(bus.req_ready),   32'd0);
      check("rst_valid",     32'(bus.rsp_valid),   32'd0);
      check("rst_data",      32'(bus.rsp_data),    32'd0);
      check("rst_ptr",       32'(bus.rsp_pointer), 32'd0);
      check("rst_last",      32'(bus.rsp_last),    32'd0);
      check("rst_busy",      32'(busy),            32'd0);
      rst_n = 1'b1;
      #1;
      check("rel_req_ready", 32'(bus.req_ready), 32'd1);

      // preload
      for (int i = 0; i < 4; i++) load(8'h10 + 8'(i), 16'hA000 + 16'(i));
      load(8'hFE, 16'hB0FE); load(8'hFF, 16'hB0FF);
      load(8'h00, 16'hB000); load(8'h01, 16'hB001);
      for (int i = 0; i < 4; i++) load(8'h20 + 8'(i), 16'hD000 + 16'(i));
      for (int i = 0; i < 4; i++) load(8'h30 + 8'(i), 16'hE000 + 16'(i));

      // basic burst
      issue(2'd1, 1'b1, 8'h10);
      burst_plain("t1", 16'hA000, 16'hA001, 16'hA002, 16'hA003);

      // non-matching requests
      issue(2'd2, 1'b1, 8'h10);
      for (int i = 0; i < 3; i++) begin check_idle("nm_dev"); tick(); end
      issue(2'd1, 1'b0, 8'h10);
      for (int i = 0; i < 3; i++) begin check_idle("nm_flag"); tick(); end

      // address wrap
      issue(2'd1, 1'b1, 8'hFE);
      burst_plain("wrap", 16'hB0FE, 16'hB0FF, 16'hB000, 16'hB001);

      // backpressure on beat 1
      hs_start = hs_cnt;
      issue(2'd1, 1'b1, 8'h20);
      tick(); tick();
      check("bp_b0_data", 32'(bus.rsp_data), 32'hD000);
      tick();
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("bp_hold_valid", 32'(bus.rsp_valid),   32'd1);
         check("bp_hold_data",  32'(bus.rsp_data),    32'hD001);
         check("bp_hold_ptr",   32'(bus.rsp_pointer), 32'd1);
         tick();
      end
      bus.rsp_ready = 1'b1;
      check("bp_b1_data", 32'(bus.rsp_data), 32'hD001);
      tick();
      check("bp_b2_data", 32'(bus.rsp_data),    32'hD002);
      check("bp_b2_ptr",  32'(bus.rsp_pointer), 32'd2);
      tick();
      check("bp_b3_data", 32'(bus.rsp_data), 32'hD003);
      check("bp_b3_last", 32'(bus.rsp_last), 32'd1);
      tick();
      check_idle("bp_end");
      check("bp_handshakes", 32'(hs_cnt - hs_start), 32'd4);

      // load collision on a held beat
      issue(2'd1, 1'b1, 8'h30);
      tick(); tick();
      check("col_b0_data", 32'(bus.rsp_data), 32'hE000);
      tick();
      bus.rsp_ready = 1'b0;
      ld_en = 1'b1; ld_addr = 8'h31; ld_data = 16'hBEEF;
      check("col_old_data", 32'(bus.rsp_data), 32'hE001);
      tick();
      ld_en = 1'b0;
      check("col_new_data", 32'(bus.rsp_data),    32'hBEEF);
      check("col_new_ptr",  32'(bus.rsp_pointer), 32'd1);
      bus.rsp_ready = 1'b1;
      tick();
      check("col_b2_data", 32'(bus.rsp_data), 32'hE002);
      tick();
      check("col_b3_data", 32'(bus.rsp_data), 32'hE003);
      tick();
      check_idle("col_end");

      // reset mid-burst
      issue(2'd1, 1'b1, 8'h10);
      tick(); tick(); tick();
      check("mr_b1_ptr", 32'(bus.rsp_pointer), 32'd1);
      tick();
      rst_n = 1'b0;
      #1;
      check("mr_valid",     32'(bus.rsp_valid), 32'd0);
      check("mr_busy",      32'(busy),          32'd0);
      check("mr_req_ready", 32'(bus.req_ready), 32'd0);
      tick();
      rst_n = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) begin check_idle("mr_after"); tick(); end
      issue(2'd1, 1'b1, 8'h10);
      burst_plain("mr_new", 16'hA000, 16'hA001, 16'hA002, 16'hA003);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
